bcd_scan_display: RTL and testbench

Multiplexed seven-segment display driver that sits directly downstream of the binary-to-decimal conversion logic (`circuitA` and its comparator/mux companions). It captures a word of BCD digits on a load strobe and drives a common-anode display one digit at a time. It keeps a refresh prescaler, a rotating digit index, optional leading-zero blanking, and a dash pattern for out-of-range nibbles. All outputs are registered, so the board pins are glitch-free.

---
 rtl/bcd_scan_display.sv | 99 +++++++++
 tb/tb_bcd_scan_display.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode seven-segment driver: latches a BCD word on load and
// scans one digit per PRESCALE cycles, with optional leading-zero blanking.
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(PRESCALE);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic [NUM_DIGITS:0]     zero_from;
  logic [3:0]              nib;
  logic                    blank_cand;

  // Active-low {g,f,e,d,c,b,a}; any non-BCD nibble renders as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

  assign tick = (pcnt_q == PCNT_MAX);

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    idx_d  = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    hold_d = load ? digits_in : hold_q;

    // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero.
    zero_from = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && (hold_q[4*i +: 4] == 4'd0);

    nib        = 4'd0;
    blank_cand = 1'b0;
    an_d       = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib        = hold_q[4*i +: 4];
        blank_cand = (i != 0) && zero_from[i];
        an_d[i]    = 1'b0;
      end
    end

    seg_d = (blank_lz && blank_cand) ? SEG_BLANK : seg_decode(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      hold_q <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: a cycle-count reference model pushes the
// expected display state per edge; a monitor pops and compares on the falling edge.
module tb_bcd_scan_display;

  localparam int N = 4;
  localparam int P = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic           clk;
  logic           reset;
  logic           load;
  logic [4*N-1:0] digits_in;
  logic           blank_lz;
  logic [6:0]     seg;
  logic [N-1:0]   an;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
  } exp_t;

  exp_t q[$];
  int   asserts = 0;
  int   fails   = 0;

  int hd [N];
  int ncyc = 0;

  bcd_scan_display #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: after k unreset edges the lit digit is (k / P) % N.
  always @(posedge clk) begin
    exp_t e;
    int   ix;
    bit   allz;
    if (reset) begin
      e.seg = 7'h7F;
      e.an  = '1;
      for (int i = 0; i < N; i++) hd[i] = 0;
      ncyc = 0;
    end else begin
      ix = (ncyc / P) % N;
      e.an = '1;
      e.an[ix] = 1'b0;
      allz = 1'b1;
      for (int j = ix; j < N; j++) if (hd[j] != 0) allz = 1'b0;
      if (blank_lz && ix > 0 && allz) e.seg = 7'h7F;
      else if (hd[ix] > 9)            e.seg = 7'h3F;
      else                            e.seg = SEG_TAB[hd[ix]];
      if (load) for (int i = 0; i < N; i++) hd[i] = int'(digits_in[4*i +: 4]);
      ncyc++;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      asserts++;
      if (seg !== e.seg) begin
        fails++;
        $display("FAIL seg t=%0t actual=%h expected=%h", $time, seg, e.seg);
      end
      asserts++;
      if (an !== e.an) begin
        fails++;
        $display("FAIL an t=%0t actual=%h expected=%h", $time, an, e.an);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [4*N-1:0] v);
    load = 1'b1;
    digits_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [4*N-1:0] rand_word();
    logic [4*N-1:0] v;
    int nz;
    v  = 4*N'($urandom);
    nz = $urandom_range(0, N);
    for (int i = N - nz; i < N; i++) v[4*i +: 4] = 4'd0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 2) != 0) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0; blank_lz = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(20);
    ld(16'h1234);
    idle(20);
    blank_lz = 1'b1;
    ld(16'h0007);
    idle(20);
    ld(16'h0000);
    idle(20);
    ld(16'h0A05);
    idle(20);
    // Loads landing at each prescaler phase, including the tick edge.
    for (int k = 0; k < 6; k++) begin
      ld(rand_word());
      idle(k + 1);
    end
    // Reset mid-frame together with a load.
    idle(9);
    reset = 1'b1; load = 1'b1; digits_in = 16'h9999;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    idle(20);
    // Load held high continuously.
    load = 1'b1;
    for (int k = 0; k < 12; k++) begin
      digits_in = rand_word();
      @(negedge clk);
    end
    load = 1'b0;
    idle(8);
    for (int k = 0; k < 3000; k++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) digits_in = rand_word();
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; load = 1'b0;
    idle(3);
    #1;
    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
